// File: rtl/uart_rsp_serializer_if.sv
// Bundle of the response-capture and UART TX streaming signals of
// uart_rsp_serializer.
//   rsp_*        : response strobe and payload from the host adapter
//   rsp_space_o  : FIFO not full (bridge may issue a new request)
//   tx_*         : valid/ready byte stream towards the UART core
//   idle_o       : nothing queued and no frame in flight
//   ovf_o/clr    : sticky drop flag and its clear
//   drop_cnt_o   : saturating count of dropped responses
// The slave modport is the serializer; the master modport is its environment.
interface uart_rsp_serializer_if;
    logic        rsp_valid_i;
    logic        rsp_we_i;
    logic [31:0] rsp_rdata_i;
    logic        rsp_err_i;
    logic        rsp_intg_err_i;
    logic        rsp_space_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        idle_o;
    logic        ovf_o;
    logic        ovf_clr_i;
    logic [7:0]  drop_cnt_o;

    modport slave (
        input  rsp_valid_i, rsp_we_i, rsp_rdata_i, rsp_err_i, rsp_intg_err_i,
        input  tx_ready_i, ovf_clr_i,
        output rsp_space_o, tx_valid_o, tx_data_o, idle_o, ovf_o, drop_cnt_o
    );

    modport master (
        output rsp_valid_i, rsp_we_i, rsp_rdata_i, rsp_err_i, rsp_intg_err_i,
        output tx_ready_i, ovf_clr_i,
        input  rsp_space_o, tx_valid_o, tx_data_o, idle_o, ovf_o, drop_cnt_o
    );
endinterface

// File: rtl/uart_rsp_serializer.sv
// Response-return stage of the UART host bridge. Completed host-adapter
// responses are buffered in a small FIFO (the adapter strobe cannot be
// stalled) and each one is serialised as a byte frame on the UART TX stream:
// a status byte {StatusTag, 0, intg_err, err, we}, followed by the four read
// data bytes (LSB first) only for error-free reads.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (aborts any frame, empties FIFO)
//   bus    : uart_rsp_serializer_if.slave (response in, TX stream out, status)
module uart_rsp_serializer #(
    parameter int unsigned RspDepth  = 2,
    parameter logic [3:0]  StatusTag = 4'hA
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    uart_rsp_serializer_if.slave  bus
);
    localparam int unsigned    PtrW     = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned    CntW     = PtrW + 1;
    localparam logic [CntW-1:0] DepthVal = CntW'(RspDepth);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic        we;
        logic        err;
        logic        intg_err;
        logic [31:0] rdata;
    } rsp_t;

    function automatic logic [7:0] status_byte(input rsp_t r);
        return {StatusTag, 1'b0, r.intg_err, r.err, r.we};
    endfunction

    // Only error-free reads carry data bytes after the status byte.
    function automatic logic has_payload(input rsp_t r);
        return !(r.we || r.err || r.intg_err);
    endfunction

    rsp_t            fifo_mem_r [RspDepth];
    logic [PtrW-1:0] wr_ptr_r;
    logic [PtrW-1:0] rd_ptr_r;
    logic [CntW-1:0] count_r;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            drop_s;
    rsp_t            push_entry_s;
    rsp_t            head_s;

    state_e          state_r;
    state_e          state_d;
    logic            tx_valid_r;
    logic            tx_valid_d;
    logic [7:0]      tx_data_r;
    logic [7:0]      tx_data_d;
    logic [31:0]     rdata_r;
    logic [31:0]     rdata_d;
    logic            has_data_r;
    logic            has_data_d;
    logic [1:0]      byte_idx_r;
    logic [1:0]      byte_idx_d;
    logic            ovf_r;
    logic [7:0]      drop_cnt_r;

    assign full_s       = (count_r == DepthVal);
    assign empty_s      = (count_r == {CntW{1'b0}});
    assign push_entry_s = '{we: bus.rsp_we_i, err: bus.rsp_err_i,
                            intg_err: bus.rsp_intg_err_i, rdata: bus.rsp_rdata_i};
    assign head_s       = fifo_mem_r[rd_ptr_r];
    // A pop in the same cycle frees the slot the incoming response needs.
    assign push_s       = bus.rsp_valid_i && (!full_s || pop_s);
    assign drop_s       = bus.rsp_valid_i && full_s && !pop_s;

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PtrW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PtrW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; stale contents are harmless because reset clears the count
    always_ff @(posedge clk_i) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= push_entry_s;
    end

    // Frame FSM next-state and output-register values
    always_comb begin
        state_d    = state_r;
        tx_valid_d = tx_valid_r;
        tx_data_d  = tx_data_r;
        rdata_d    = rdata_r;
        has_data_d = has_data_r;
        byte_idx_d = byte_idx_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = status_byte(head_s);
                    rdata_d    = head_s.rdata;
                    has_data_d = has_payload(head_s);
                    byte_idx_d = 2'd0;
                    state_d    = ST_SEND;
                end else begin
                    tx_valid_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (bus.tx_ready_i) begin
                    if (has_data_r) begin
                        tx_data_d  = rdata_r[{byte_idx_r, 3'b000} +: 8];
                        has_data_d = (byte_idx_r != 2'd3);
                        byte_idx_d = byte_idx_r + 2'd1;
                    end else if (!empty_s) begin
                        // back-to-back frame: next status byte with no bubble
                        pop_s      = 1'b1;
                        tx_data_d  = status_byte(head_s);
                        rdata_d    = head_s.rdata;
                        has_data_d = has_payload(head_s);
                        byte_idx_d = 2'd0;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    tx_valid_d = tx_valid_r;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state and registered TX outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            rdata_r    <= 32'h0000_0000;
            has_data_r <= 1'b0;
            byte_idx_r <= 2'd0;
        end else begin
            state_r    <= state_d;
            tx_valid_r <= tx_valid_d;
            tx_data_r  <= tx_data_d;
            rdata_r    <= rdata_d;
            has_data_r <= has_data_d;
            byte_idx_r <= byte_idx_d;
        end
    end

    // Sticky overflow flag (a drop wins over clear) and saturating drop count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_r      <= 1'b0;
            drop_cnt_r <= 8'h00;
        end else begin
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (bus.ovf_clr_i) begin
                ovf_r <= 1'b0;
            end
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    assign bus.rsp_space_o = !full_s;
    assign bus.tx_valid_o  = tx_valid_r;
    assign bus.tx_data_o   = tx_data_r;
    assign bus.idle_o      = (state_r == ST_IDLE) && empty_s;
    assign bus.ovf_o       = ovf_r;
    assign bus.drop_cnt_o  = drop_cnt_r;
endmodule

// File: tb/tb_uart_rsp_serializer.sv
// Self-checking bench for uart_rsp_serializer: directed scenarios plus a
// randomized phase, all compared every cycle against a queue-based
// transaction model (pending responses, bytes of the frame in flight).
module tb_uart_rsp_serializer;
    localparam int Depth = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rsp_serializer_if bus ();

    uart_rsp_serializer #(.RspDepth(Depth), .StatusTag(4'hA)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  m_frame [$];   // bytes still to be handed to the UART
    logic [34:0] m_fifo  [$];   // {we, err, intg_err, rdata} waiting
    logic        m_ovf;
    int          m_drop;
    logic [7:0]  tx_log  [$];   // bytes observed on handshakes

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expand one response into the bytes the UART must see.
    task automatic load_frame(input logic [34:0] e);
        logic [31:0] d;
        d = e[31:0];
        m_frame.push_back({4'hA, 1'b0, e[32], e[33], e[34]});
        if (!e[34] && !e[33] && !e[32]) begin
            for (int b = 0; b < 4; b++) m_frame.push_back(d[8*b +: 8]);
        end
    endtask

    // Check the current cycle, then advance the model across the next edge.
    task automatic step();
        bit hs, pop, full, dropped;
        logic [34:0] e;
        check_val("tx_valid", bus.tx_valid_o, m_frame.size() > 0);
        if (m_frame.size() > 0) check_val("tx_data", bus.tx_data_o, m_frame[0]);
        check_val("rsp_space", bus.rsp_space_o, m_fifo.size() < Depth);
        check_val("idle", bus.idle_o, (m_frame.size() == 0) && (m_fifo.size() == 0));
        check_val("ovf", bus.ovf_o, m_ovf);
        check_val("drop_cnt", bus.drop_cnt_o, m_drop);
        if (bus.tx_valid_o && bus.tx_ready_i) tx_log.push_back(bus.tx_data_o);
        if (rst) begin
            m_frame.delete();
            m_fifo.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            hs      = (m_frame.size() > 0) && bus.tx_ready_i;
            full    = (m_fifo.size() == Depth);
            dropped = 1'b0;
            if (hs) void'(m_frame.pop_front());
            pop = (m_frame.size() == 0) && (m_fifo.size() > 0);
            if (pop) begin
                e = m_fifo.pop_front();
                load_frame(e);
            end
            if (bus.rsp_valid_i) begin
                if (!full || pop) begin
                    m_fifo.push_back({bus.rsp_we_i, bus.rsp_err_i, bus.rsp_intg_err_i, bus.rsp_rdata_i});
                end else begin
                    dropped = 1'b1;
                    m_ovf   = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (bus.ovf_clr_i && !dropped) m_ovf = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drive_rsp(input logic we, input logic err, input logic intg, input logic [31:0] rd);
        bus.rsp_valid_i    = 1'b1;
        bus.rsp_we_i       = we;
        bus.rsp_err_i      = err;
        bus.rsp_intg_err_i = intg;
        bus.rsp_rdata_i    = rd;
        step();
        bus.rsp_valid_i    = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [31:0] rd;
        bus.rsp_valid_i    = 1'b0;
        bus.rsp_we_i       = 1'b0;
        bus.rsp_err_i      = 1'b0;
        bus.rsp_intg_err_i = 1'b0;
        bus.rsp_rdata_i    = 32'h0;
        bus.tx_ready_i     = 1'b1;
        bus.ovf_clr_i      = 1'b0;
        m_ovf              = 1'b0;
        m_drop             = 0;
        rst                = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_tx_data", bus.tx_data_o, 8'h00);
        rst = 1'b0;
        steps(2);

        // Read OK: latency N+2, five bytes in order
        tx_log.delete();
        drive_rsp(1'b0, 1'b0, 1'b0, 32'h1234_5678);
        step();
        check_val("lat_valid", bus.tx_valid_o, 1'b1);
        check_val("lat_status", bus.tx_data_o, 8'hA0);
        steps(8);
        check_val("rd_len", tx_log.size(), 5);
        if (tx_log.size() == 5) begin
            check_val("rd_b0", tx_log[0], 8'hA0);
            check_val("rd_b1", tx_log[1], 8'h78);
            check_val("rd_b2", tx_log[2], 8'h56);
            check_val("rd_b3", tx_log[3], 8'h34);
            check_val("rd_b4", tx_log[4], 8'h12);
        end
        check_val("rd_idle", bus.idle_o, 1'b1);

        // Write OK then errored read: status bytes only
        tx_log.delete();
        drive_rsp(1'b1, 1'b0, 1'b0, 32'h0);
        drive_rsp(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        steps(8);
        check_val("err_len", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            check_val("wr_status", tx_log[0], 8'hA1);
            check_val("err_status", tx_log[1], 8'hA2);
        end

        // Write with integrity error
        tx_log.delete();
        drive_rsp(1'b1, 1'b0, 1'b1, 32'h0);
        steps(5);
        check_val("intg_len", tx_log.size(), 1);
        if (tx_log.size() == 1) check_val("intg_status", tx_log[0], 8'hA5);

        // Backpressure: ready one cycle in three
        tx_log.delete();
        bus.tx_ready_i = 1'b0;
        drive_rsp(1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
        for (int i = 0; i < 24; i++) begin
            bus.tx_ready_i = (i % 3 == 2);
            step();
        end
        bus.tx_ready_i = 1'b1;
        steps(3);
        check_val("bp_len", tx_log.size(), 5);
        if (tx_log.size() == 5) begin
            check_val("bp_b0", tx_log[0], 8'hA0);
            check_val("bp_b1", tx_log[1], 8'h0D);
            check_val("bp_b4", tx_log[4], 8'hCA);
        end

        // Overflow with the UART stalled
        tx_log.delete();
        bus.tx_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) drive_rsp(1'b0, 1'b0, 1'b0, 32'h1111_1111 * (i + 1));
        check_val("ovf_set", bus.ovf_o, 1'b1);
        check_val("ovf_cnt", bus.drop_cnt_o, 8'd1);
        check_val("ovf_space", bus.rsp_space_o, 1'b0);
        bus.tx_ready_i = 1'b1;
        steps(20);
        check_val("ovf_frames", tx_log.size(), 15);
        bus.ovf_clr_i = 1'b1;
        step();
        bus.ovf_clr_i = 1'b0;
        step();
        check_val("ovf_clr", bus.ovf_o, 1'b0);
        check_val("ovf_cnt_kept", bus.drop_cnt_o, 8'd1);

        // Reset mid-frame with one entry queued
        tx_log.delete();
        drive_rsp(1'b0, 1'b0, 1'b0, 32'h89AB_CDEF);
        drive_rsp(1'b0, 1'b0, 1'b0, 32'h0101_0101);
        steps(2);
        bus.tx_ready_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.tx_ready_i = 1'b1;
        check_val("rst_valid", bus.tx_valid_o, 1'b0);
        check_val("rst_idle", bus.idle_o, 1'b1);
        steps(10);
        check_val("rst_len", tx_log.size(), 2);

        // Randomized traffic, drops and clears included
        for (int i = 0; i < 400; i++) begin
            bus.tx_ready_i     = ($urandom_range(0, 3) != 0);
            bus.ovf_clr_i      = ($urandom_range(0, 15) == 0);
            bus.rsp_valid_i    = ($urandom_range(0, 2) == 0);
            bus.rsp_we_i       = $urandom_range(0, 1);
            bus.rsp_err_i      = ($urandom_range(0, 3) == 0);
            bus.rsp_intg_err_i = ($urandom_range(0, 7) == 0);
            rd                 = $urandom;
            bus.rsp_rdata_i    = rd;
            step();
        end
        bus.rsp_valid_i = 1'b0;
        bus.ovf_clr_i   = 1'b0;
        bus.tx_ready_i  = 1'b1;
        steps(20);

        // Drop counter saturation
        bus.tx_ready_i = 1'b0;
        for (int i = 0; i < 262; i++) drive_rsp(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("drop_sat", bus.drop_cnt_o, 8'hFF);
        bus.tx_ready_i = 1'b1;
        steps(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
